// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N valid/ready stream demux with broadcast; STREAM_DEMUX_CNT_EN adds per-channel delivery counters
module stream_demux #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic                  in_bcast,
   output logic [2**SEL_W-1:0]   out_valid,
   input  logic [2**SEL_W-1:0]   out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  busy
`ifdef STREAM_DEMUX_CNT_EN
   ,
   output logic [2**SEL_W*16-1:0] cnt
`endif
);
   localparam int N = 2**SEL_W;
   logic [N-1:0]     pending;
   logic [N-1:0]     drained;
   logic [WIDTH-1:0] hold_data;
   logic             accept;
   assign drained   = pending & ~out_ready;
   assign in_ready  = !rst && en && drained == '0;
   assign accept    = in_valid && in_ready;
   assign out_valid = pending;
   assign out_data  = hold_data;
   assign busy      = |pending;
   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         hold_data <= '0;
      end else if (accept) begin
         pending   <= in_bcast ? '1 : {{(N-1){1'b0}}, 1'b1} << in_sel;
         hold_data <= in_data;
      end else begin
         pending   <= drained;
      end
   end
`ifdef STREAM_DEMUX_CNT_EN
   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rst)
            cnt[16*i +: 16] <= '0;
         else if (pending[i] && out_ready[i])
            cnt[16*i +: 16] <= cnt[16*i +: 16] + 16'd1;
      end
   end
`endif
endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered, parametrised 1-to-N stream demultiplexer with valid/ready handshake and global enable.
- Each word is routed to the output channel addressed by a select field, or broadcast to all channels.
- A single holding register decouples the producer from the consumers. Intended as the sequential successor of the combinational 2-to-4 enable demux, for routing streams to per-lane consumers.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- SEL_W, 2, select width; channel count N = 2**SEL_W (SEL_W >= 1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- en  input  1  accept enable; 0 blocks new input, held word still drains
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts a word this cycle
- in_data  input  WIDTH  word payload
- in_sel  input  SEL_W  destination channel index
- in_bcast  input  1  1 = deliver to all N channels, in_sel ignored
- out_valid  output  N  per-channel valid; bit i = word pending for channel i
- out_ready  input  N  per-channel consumer ready
- out_data  output  WIDTH  held payload, shared by all channels
- busy  output  1  holding register occupied (pending mask non-zero)

Behaviour:
- State is a data register hold_data[WIDTH] and a mask pending[N]. out_valid = pending. out_data = hold_data. busy = |pending.
- Reset: pending = 0 and hold_data = 0, so out_valid = 0, out_data = 0, busy = 0. in_ready is driven 0 while rst is high.
- Channel i takes the word when out_valid[i] && out_ready[i]. The cleared mask is drained = pending & ~out_ready.
- in_ready = en && (drained == 0), combinational. This allows a back-to-back transfer in the same cycle the last pending channel accepts.
- Accept = in_valid && in_ready. On accept:
  - hold_data <= in_data.
  - pending <= all ones if in_bcast, else one-hot(in_sel).
- No accept: pending <= drained, and hold_data keeps its value.
- Latency: a word accepted in cycle t is visible on out_valid/out_data in cycle t+1. Throughput is 1 word/cycle when the consumer is always ready.
- Broadcast: the word is retired only when every channel has accepted it. Channels may accept in different cycles. Each channel sees the word exactly once; its out_valid bit drops after its own handshake.
- out_valid bits and out_data are stable while not accepted. No combinational path exists from in_* to out_*.
- en = 0 mid-drain: pending keeps draining normally; only acceptance stops. en has no effect on held state.
- in_valid = 0: in_ready may still be 1. Nothing is loaded.
- in_sel and in_data are don't-care when in_valid = 0.
- Reset mid-operation: a held word is discarded immediately, and out_valid = 0 from the next cycle.
- out_ready bits for non-pending channels are ignored.

Optional Feature:
- Macro STREAM_DEMUX_CNT_EN.
- Defined:
  - Adds output port cnt  output  N*16  one 16-bit delivered-word counter per channel, channel i at bits [16*i+15:16*i].
  - Counter i increments on each out_valid[i] && out_ready[i] handshake.
  - Counters wrap from 16'hFFFF to 0.
  - Counters reset to 0 on rst.
- Undefined: no cnt port and no counter logic. All other behaviour is identical.

Test Plan (WIDTH=8, SEL_W=2):
- Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=4'b0000, out_data=8'h00, busy=0.
- Unicast: en=1, out_ready=4'b1111, send 8'hA0/sel0, 8'hA1/sel1, 8'hA2/sel2, 8'hA3/sel3 on consecutive cycles -> out_valid 0001, 0010, 0100, 1000 one cycle after each, with matching data. in_ready stays 1 (4 words in 4 cycles).
- Backpressure: send 8'h5A to sel2 with out_ready=4'b0000 for 3 cycles -> out_valid=4'b0100 and data 8'h5A held, in_ready=0. Raise out_ready[2] -> in_ready=1 the same cycle, out_valid clears next cycle (or shows the new word if one was accepted).
- Broadcast: in_bcast=1, data 8'hC3, out_ready staggered 0001, 0100, 1010 over 3 cycles -> out_valid 1111 -> 1110 -> 1010 -> 0000. in_ready=1 only in the cycle of the 1010 handshake.
- Enable: en=0 with in_valid=1 -> in_ready=0, nothing accepted. A previously held word still drains. en=1 -> accept resumes.
- Counter (STREAM_DEMUX_CNT_EN): after unicast + broadcast tests, cnt per channel equals its handshake count. Preload channel 0 via 65536 deliveries -> cnt[15:0] wraps to 0.
